// File: rtl/song_pkg.sv
// Shared song-selection definitions: song IDs, the default song count, the FSM state
// encoding, button lane indices and the wrapping index helpers.
package song_pkg;

    localparam logic [3:0] SONG_STAR = 4'd1;
    localparam logic [3:0] SONG_BDAY = 4'd2;
    localparam logic [3:0] SONG_YEAR = 4'd3;

    localparam int DEFAULT_NUM_SONGS = 3;

    typedef enum logic {
        ST_BROWSE = 1'b0,
        ST_PLAY   = 1'b1
    } state_t;

    // Lane order of the three front-panel buttons inside the debouncer bank
    localparam int BTN_NEXT    = 0;
    localparam int BTN_PREV    = 1;
    localparam int BTN_CONFIRM = 2;
    localparam int NUM_BTNS    = 3;

    // Step forward through 1..last; anything at or past last wraps to 1
    function automatic logic [3:0] song_inc(input logic [3:0] cur, input logic [3:0] last);
        return (cur >= last) ? 4'd1 : cur + 4'd1;
    endfunction

    // Step backward through 1..last; 1 (or an out-of-range 0) wraps to last
    function automatic logic [3:0] song_dec(input logic [3:0] cur, input logic [3:0] last);
        return (cur <= 4'd1) ? last : cur - 4'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button lane: 2-flop synchronizer, stable-count debouncer and
// rising-edge press detector.
module button_debounce #(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The count only runs while the synchronized input disagrees with the accepted level
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/song_select.sv
// Front-panel song selection: three debounced buttons drive a wrapping song index
// and a BROWSE/PLAY state machine that hands the confirmed song to playback.
module song_select
    import song_pkg::*;
#(
    parameter int NUM_SONGS = DEFAULT_NUM_SONGS,
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    output logic [3:0] num,
    output logic [3:0] play_num,
    output logic       playing,
    output logic       play_start
);

    localparam logic [3:0] LAST_SONG = 4'(NUM_SONGS);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;

    state_t     state_q;
    logic [3:0] num_q;
    logic [3:0] play_num_q;
    logic       playing_q;
    logic       play_start_q;

    logic       step_next;
    logic       step_prev;

    assign btn_raw[BTN_NEXT]    = btn_next;
    assign btn_raw[BTN_PREV]    = btn_prev;
    assign btn_raw[BTN_CONFIRM] = btn_confirm;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            button_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .reset(reset),
                .raw  (btn_raw[gi]),
                .level(btn_level[gi]),
                .press(btn_press[gi])
            );
        end
    endgenerate

    // Simultaneous next+prev cancel; confirm outranks both inside the FSM
    assign step_next = btn_press[BTN_NEXT] & ~btn_press[BTN_PREV];
    assign step_prev = btn_press[BTN_PREV] & ~btn_press[BTN_NEXT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BROWSE;
            num_q        <= SONG_STAR;
            play_num_q   <= 4'd0;
            playing_q    <= 1'b0;
            play_start_q <= 1'b0;
        end else begin
            play_start_q <= 1'b0;
            case (state_q)
                ST_BROWSE: begin
                    if (btn_press[BTN_CONFIRM]) begin
                        play_num_q   <= num_q;
                        playing_q    <= 1'b1;
                        play_start_q <= 1'b1;
                        state_q      <= ST_PLAY;
                    end else if (step_next) begin
                        num_q <= song_inc(num_q, LAST_SONG);
                    end else if (step_prev) begin
                        num_q <= song_dec(num_q, LAST_SONG);
                    end
                end
                ST_PLAY: begin
                    if (btn_press[BTN_CONFIRM]) begin
                        play_num_q <= 4'd0;
                        playing_q  <= 1'b0;
                        state_q    <= ST_BROWSE;
                    end
                end
                default: begin
                    state_q <= ST_BROWSE;
                end
            endcase
        end
    end

    assign num        = num_q;
    assign play_num   = play_num_q;
    assign playing    = playing_q;
    assign play_start = play_start_q;

endmodule

// File: tb/tb_song_select.sv
// Self-checking bench for song_select: directed vector table, hand-timed corner
// sequences, and randomized presses checked against a behavioural model.
module tb_song_select;

    localparam int DB = 4;
    localparam int NS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_confirm;
    logic [3:0] num;
    logic [3:0] play_num;
    logic       playing;
    logic       play_start;

    int checks = 0;
    int passed = 0;
    int ps_count = 0;

    // Behavioural model state
    int m_num;
    int m_playing;
    int m_play_num;

    typedef struct {
        bit n;
        bit p;
        bit c;
        int hold;
        int exp_num;
        int exp_playing;
        int exp_play_num;
        int exp_start;
    } vec_t;

    vec_t vecs[13];

    song_select #(
        .NUM_SONGS(NS),
        .DB_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .btn_confirm(btn_confirm),
        .num        (num),
        .play_num   (play_num),
        .playing    (playing),
        .play_start (play_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (play_start === 1'b1) ps_count++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_x(input string name, input logic [3:0] act, input int exp);
        checks++;
        if (!$isunknown(act) && int'(act) == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raw buttons are raised just after an edge, so the next edge is edge 1
    task automatic press(input bit n, input bit p, input bit c, input int hold, input int idle);
        btn_next    = n;
        btn_prev    = p;
        btn_confirm = c;
        step(hold);
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        btn_confirm = 1'b0;
        step(idle);
    endtask

    // Applies the front-panel rules to one accepted simultaneous press set
    function automatic int model_start(input bit n, input bit p, input bit c);
        int started = 0;
        if (c) begin
            if (m_playing == 0) begin
                m_play_num = m_num;
                m_playing  = 1;
                started    = 1;
            end else begin
                m_play_num = 0;
                m_playing  = 0;
            end
        end else if (m_playing == 0 && n && !p) begin
            m_num = (m_num == NS) ? 1 : m_num + 1;
        end else if (m_playing == 0 && p && !n) begin
            m_num = (m_num == 1) ? NS : m_num - 1;
        end
        return started;
    endfunction

    task automatic model_reset();
        m_num      = 1;
        m_playing  = 0;
        m_play_num = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        model_reset();
        step(1);
    endtask

    initial begin
        int ps0;
        int exp_start;
        reset       = 1'b1;
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        btn_confirm = 1'b0;

        vecs[0]  = '{1, 0, 0, DB + 1, 2, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, DB + 3, 3, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, DB,     1, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, DB + 2, 3, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, DB - 1, 3, 0, 0, 0};
        vecs[5]  = '{1, 1, 0, DB + 2, 3, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, DB + 2, 2, 0, 0, 0};
        vecs[7]  = '{0, 0, 1, DB + 2, 2, 1, 2, 1};
        vecs[8]  = '{1, 0, 0, DB + 2, 2, 1, 2, 0};
        vecs[9]  = '{0, 0, 1, DB + 2, 2, 0, 0, 0};
        vecs[10] = '{1, 0, 1, DB + 2, 2, 1, 2, 1};
        vecs[11] = '{0, 1, 0, DB + 2, 2, 1, 2, 0};
        vecs[12] = '{0, 0, 1, DB + 2, 2, 0, 0, 0};

        // Reset state and quiet operation
        step(2);
        check_x("reset_num", num, 1);
        check_x("reset_play_num", play_num, 0);
        check("reset_playing", int'(playing), 0);
        reset = 1'b0;
        model_reset();
        step(12);
        check_x("idle_num", num, 1);
        check("idle_playing", int'(playing), 0);
        check("idle_no_start", ps_count, 0);

        // Exact latency: num changes at edge DB+3 and not before
        btn_next = 1'b1;
        step(DB + 2);
        check_x("latency_before", num, 1);
        step(1);
        check_x("latency_at", num, 2);
        step(20);
        check_x("hold_one_action", num, 2);
        btn_next = 1'b0;
        step(DB + 6);
        $display("txn latency: num=%0d", num);

        // play_start is high for exactly the cycle after entering PLAY
        btn_confirm = 1'b1;
        step(DB + 2);
        check("start_before", int'(play_start), 0);
        step(1);
        check("start_high", int'(play_start), 1);
        check_x("start_play_num", play_num, 2);
        step(1);
        check("start_low_after", int'(play_start), 0);
        btn_confirm = 1'b0;
        step(DB + 6);
        press(0, 0, 1, DB + 1, DB + 6);
        check("back_to_browse", int'(playing), 0);
        $display("txn confirm pair: playing=%0d play_num=%0d", playing, play_num);

        // Directed vector table from a fresh reset
        do_reset();
        foreach (vecs[i]) begin
            ps0 = ps_count;
            press(vecs[i].n, vecs[i].p, vecs[i].c, vecs[i].hold, DB + 6);
            $display("txn vec%0d n=%0d p=%0d c=%0d hold=%0d -> num=%0d playing=%0d play_num=%0d",
                     i, vecs[i].n, vecs[i].p, vecs[i].c, vecs[i].hold, num, playing, play_num);
            check_x($sformatf("vec%0d_num", i), num, vecs[i].exp_num);
            check($sformatf("vec%0d_playing", i), int'(playing), vecs[i].exp_playing);
            check_x($sformatf("vec%0d_play_num", i), play_num, vecs[i].exp_play_num);
            check($sformatf("vec%0d_start", i), ps_count - ps0, vecs[i].exp_start);
        end

        // Reset mid-PLAY with next held: asynchronous return, then one debounced press
        press(1, 0, 0, DB + 1, DB + 6);
        check_x("pre_rst_num", num, 3);
        press(0, 0, 1, DB + 1, DB + 6);
        check("pre_rst_playing", int'(playing), 1);
        btn_next = 1'b1;
        step(3);
        reset = 1'b1;
        #2;
        check_x("async_rst_num", num, 1);
        check_x("async_rst_play_num", play_num, 0);
        check("async_rst_playing", int'(playing), 0);
        check("async_rst_start", int'(play_start), 0);
        step(2);
        reset = 1'b0;
        model_reset();
        step(DB + 2);
        check_x("post_rst_before", num, 1);
        step(1);
        check_x("post_rst_at", num, 2);
        btn_next = 1'b0;
        step(DB + 6);
        m_num = 2;
        $display("txn reset mid-play: num=%0d", num);

        // Randomized presses and glitches against the model
        for (int t = 0; t < 60; t++) begin
            bit rn, rp, rc;
            int hold;
            int idle;
            rn   = 1'($urandom_range(0, 1));
            rp   = 1'($urandom_range(0, 1));
            rc   = ($urandom_range(0, 2) == 0);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB - 1))
                                               : int'($urandom_range(DB, DB + 6));
            idle = int'($urandom_range(DB + 4, DB + 10));
            ps0  = ps_count;
            press(rn, rp, rc, hold, idle);
            exp_start = (hold >= DB) ? model_start(rn, rp, rc) : 0;
            $display("txn rand%0d n=%0d p=%0d c=%0d hold=%0d -> num=%0d playing=%0d play_num=%0d",
                     t, rn, rp, rc, hold, num, playing, play_num);
            check_x($sformatf("rand%0d_num", t), num, m_num);
            check($sformatf("rand%0d_playing", t), int'(playing), m_playing);
            check_x($sformatf("rand%0d_play_num", t), play_num, m_play_num);
            check($sformatf("rand%0d_start", t), ps_count - ps0, exp_start);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/song_select.md
# song_select

Front-panel song selection stage that drives the 4-bit song number consumed by the seven-segment song display. It debounces three raw push-buttons (next, previous, confirm), keeps a wrapping song index, and runs a BROWSE/PLAY state machine. It hands the confirmed song and a start pulse to the playback engine.

## Interface
- `NUM_SONGS`, default 3: number of valid songs; legal range 1..15; valid indices are 1..NUM_SONGS.
- `DB_CYCLES`, default 2_000_000: consecutive stable cycles required before a button level is accepted; minimum 2.
- `clk`  in  1: system clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `btn_next`  in  1: raw, asynchronous, active-high button; advance selection.
- `btn_prev`  in  1: raw, asynchronous, active-high button; step selection back.
- `btn_confirm`  in  1: raw, asynchronous, active-high button; start or stop playback.
- `num`  out  4: currently selected song index; feeds the display stage.
- `play_num`  out  4: song latched at confirm; 0 when not playing.
- `playing`  out  1: high while in PLAY.
- `play_start`  out  1: one-cycle pulse on entry to PLAY.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer:
  - The counter increments while the synchronized value differs from the debounced level. It clears whenever they are equal.
  - When the counter already holds DB_CYCLES-1 and the values still differ, the debounced level takes the new value and the counter clears.
  - A press pulse is the rising edge of the debounced level: one cycle wide. Releases produce no pulse.
- Pulse arbitration, evaluated per cycle:
  - confirm has top priority. If confirm pulses, next and prev are ignored that cycle.
  - If next and prev pulse in the same cycle, both are ignored.
- State BROWSE (reset state):
  - next: `num` becomes num+1; NUM_SONGS wraps to 1.
  - prev: `num` becomes num-1; 1 wraps to NUM_SONGS.
  - confirm: `play_num` becomes `num`, `play_start` pulses, `playing` goes to 1, and the state moves to PLAY.
- State PLAY:
  - next and prev are ignored; `num` is frozen.
  - confirm: `play_num` becomes 0, `playing` goes to 0, and the state moves to BROWSE.
- Arithmetic:
  - Index arithmetic is 4-bit unsigned.
  - `num` never leaves 1..NUM_SONGS.
  - With NUM_SONGS=1, next and prev leave `num` at 1.
- Reset values:
  - `num`=1, `play_num`=0, `playing`=0, `play_start`=0, state BROWSE.
  - All synchronizer flops, debounced levels and counters clear to 0.
  - Reset asserted mid-debounce or mid-PLAY returns immediately to these values. A button still held when reset releases produces one press after the full debounce period.

## Timing
- Number the first edge that samples raw high as edge 1. The raw level must then be held.
  - Debounced level rises at edge DB_CYCLES+2.
  - The press pulse is high during the following cycle.
  - `num`, state, `play_num` and `playing` update at edge DB_CYCLES+3.
- `play_start` is registered and high exactly in the cycle after the edge that enters PLAY.
- A raw high lasting fewer than DB_CYCLES synchronized cycles produces no pulse.
- A bounce back to the old level clears the counter and restarts the count.
- Holding a button produces exactly one action. A new action needs a debounced release (DB_CYCLES stable low) followed by a new press.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `song_pkg` holds:
  - song ID constants `SONG_STAR`=1, `SONG_BDAY`=2, `SONG_YEAR`=3, and the default `NUM_SONGS`=3;
  - the state encoding `ST_BROWSE`=0, `ST_PLAY`=1.
- The display stage decodes song IDs from the same package.
- Sub-module `button_debounce` (parameter DB_CYCLES; ports clk, reset, raw in, level out, press out) contains the synchronizer, counter and edge detect. It is instantiated three times.
- Selection counter and FSM live in the top module.

## Test plan
All scenarios run with DB_CYCLES=4 and NUM_SONGS=3.
- Reset, then no stimulus → `num`=1, `playing`=0, `play_num`=0, `play_start` never high.
- Hold btn_next from edge 1 → `num` goes 1→2 at edge 7. Holding 20 more cycles keeps it at 2. Release, wait 6 cycles, press again → 3; a third press → 1 (wrap).
- From `num`=1, press btn_prev → 3. A 3-cycle glitch on btn_next → `num` unchanged.
- btn_next and btn_prev raised on the same edge → `num` unchanged; btn_confirm and btn_next on the same edge → PLAY with `play_num` = old `num`, `num` unchanged.
- At `num`=2, press confirm → `playing`=1, `play_num`=2, `play_start` high for exactly 1 cycle. btn_next in PLAY → `num` stays 2. Press confirm again → `playing`=0, `play_num`=0.
- Assert reset during PLAY with `num`=3 while btn_next is held → all outputs return to reset values within the same cycle. After reset release, one press yields `num`=2 at edge 7.
